// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: facing codes, controller state encoding, playfield limits.
// The limit defaults are also used by pacman_view.
package pacman_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_PAUSED = 2'd2
  } pm_state_t;

  localparam int unsigned PF_X_MIN   = 144;
  localparam int unsigned PF_X_MAX   = 754;
  localparam int unsigned PF_Y_MIN   = 35;
  localparam int unsigned PF_Y_MAX   = 485;
  localparam int unsigned PF_X_START = 434;
  localparam int unsigned PF_Y_START = 260;

  // Several buttons at once resolve as up > down > left > right.
  function automatic logic [3:0] btn_to_dir(input logic up, input logic down,
                                            input logic left, input logic right);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return DIR_NONE;
  endfunction

endpackage

// File: rtl/pacman_motion_ctrl_if.sv
// Button/frame inputs and sprite position outputs of the Pac-Man motion controller.
// master drives buttons and frame_tick; slave is the controller.
interface pacman_motion_ctrl_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       pause;
  logic [9:0] pm_xpos;
  logic [9:0] pm_ypos;
  logic [3:0] pm_direction;
  logic       moving;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, pause,
    input  pm_xpos, pm_ypos, pm_direction, moving
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right, pause,
    output pm_xpos, pm_ypos, pm_direction, moving
  );
endinterface

// File: rtl/pacman_step_calc.sv
// Combinational next-position calculator: one step in dir, clamped to the playfield.
// With PACMAN_TUNNEL_EN a horizontal step off a limit wraps to the opposite limit.
module pacman_step_calc
  import pacman_pkg::*;
#(
  parameter int unsigned STEP  = 2,
  parameter int unsigned X_MIN = PF_X_MIN,
  parameter int unsigned X_MAX = PF_X_MAX,
  parameter int unsigned Y_MIN = PF_Y_MIN,
  parameter int unsigned Y_MAX = PF_Y_MAX
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [3:0] dir,
  output logic [9:0] nx,
  output logic [9:0] ny,
  output logic       legal
);

  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] XMIN11  = 11'(X_MIN);
  localparam logic [10:0] XMAX11  = 11'(X_MAX);
  localparam logic [10:0] YMIN11  = 11'(Y_MIN);
  localparam logic [10:0] YMAX11  = 11'(Y_MAX);
  localparam logic [9:0]  XMIN10  = 10'(X_MIN);
  localparam logic [9:0]  XMAX10  = 10'(X_MAX);
  localparam logic [9:0]  YMIN10  = 10'(Y_MIN);
  localparam logic [9:0]  YMAX10  = 10'(Y_MAX);

  logic [10:0] x11, y11, x_inc, x_dec, y_inc, y_dec;

  always_comb begin
    x11   = {1'b0, x};
    y11   = {1'b0, y};
    x_inc = x11 + STEP11;
    x_dec = x11 - STEP11;
    y_inc = y11 + STEP11;
    y_dec = y11 - STEP11;
    nx    = x;
    ny    = y;
    legal = 1'b0;
    case (dir)
      DIR_RIGHT:
        if (x11 < XMAX11) begin
          legal = 1'b1;
          nx    = (x_inc > XMAX11) ? XMAX10 : x_inc[9:0];
        end
`ifdef PACMAN_TUNNEL_EN
        else begin
          legal = 1'b1;
          nx    = XMIN10;
        end
`endif
      DIR_LEFT:
        if (x11 > XMIN11) begin
          legal = 1'b1;
          nx    = (x11 < XMIN11 + STEP11) ? XMIN10 : x_dec[9:0];
        end
`ifdef PACMAN_TUNNEL_EN
        else begin
          legal = 1'b1;
          nx    = XMAX10;
        end
`endif
      DIR_UP:
        if (y11 > YMIN11) begin
          legal = 1'b1;
          ny    = (y11 < YMIN11 + STEP11) ? YMIN10 : y_dec[9:0];
        end
      DIR_DOWN:
        if (y11 < YMAX11) begin
          legal = 1'b1;
          ny    = (y_inc > YMAX11) ? YMAX10 : y_inc[9:0];
        end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man motion controller: buffers the last requested turn and steps the sprite once every
// FRAME_DIV frames. Optional macro PACMAN_TUNNEL_EN enables horizontal wrap-around.
//
// state     | meaning
// ST_IDLE   | stationary, waiting for a legal buffered turn
// ST_MOVE   | stepping in pm_direction on every step_en
// ST_PAUSED | frozen while pause is high; returns to the state it left
module pacman_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned X_MIN     = PF_X_MIN,
  parameter int unsigned X_MAX     = PF_X_MAX,
  parameter int unsigned Y_MIN     = PF_Y_MIN,
  parameter int unsigned Y_MAX     = PF_Y_MAX,
  parameter int unsigned X_START   = PF_X_START,
  parameter int unsigned Y_START   = PF_Y_START,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pacman_motion_ctrl_if.slave   pm_if
);

  localparam logic [3:0] FDIV_M1 = 4'(FRAME_DIV - 1);

  pm_state_t  state_q, state_d, resume_q, resume_d;
  logic [3:0] pending_q, pending_d, turn_q, dir_q, dir_d, frame_cnt_q, btn_dir;
  logic [9:0] x_q, x_d, y_q, y_d, pend_nx, pend_ny, cur_nx, cur_ny;
  logic       step_en_q, pend_legal, cur_legal, take_turn, paused;

  assign btn_dir = btn_to_dir(pm_if.btn_up, pm_if.btn_down, pm_if.btn_left, pm_if.btn_right);
  assign paused  = pm_if.pause || (state_q == ST_PAUSED);

  // turn_q is pending as it stood before the current cycle's buttons, so a button arriving
  // together with frame_tick is only seen by the following step.
  pacman_step_calc #(.STEP(STEP), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX))
    u_calc_pend (.x(x_q), .y(y_q), .dir(turn_q), .nx(pend_nx), .ny(pend_ny), .legal(pend_legal));

  pacman_step_calc #(.STEP(STEP), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX))
    u_calc_cur (.x(x_q), .y(y_q), .dir(dir_q), .nx(cur_nx), .ny(cur_ny), .legal(cur_legal));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 4'd0;
      step_en_q   <= 1'b0;
    end else begin
      step_en_q <= 1'b0;
      if (pm_if.frame_tick && !paused) begin
        if (frame_cnt_q == FDIV_M1) begin
          frame_cnt_q <= 4'd0;
          step_en_q   <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      resume_q  <= ST_IDLE;
      pending_q <= DIR_NONE;
      turn_q    <= DIR_NONE;
      dir_q     <= DIR_RIGHT;
      x_q       <= 10'(X_START);
      y_q       <= 10'(Y_START);
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      pending_q <= pending_d;
      turn_q    <= take_turn ? DIR_NONE : pending_q;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    take_turn = 1'b0;
    case (state_q)
      ST_IDLE:
        if (pm_if.pause) begin
          state_d  = ST_PAUSED;
          resume_d = ST_IDLE;
        end else if (step_en_q && pend_legal) begin
          take_turn = 1'b1;
          state_d   = ST_MOVE;
        end
      ST_MOVE:
        if (pm_if.pause) begin
          state_d  = ST_PAUSED;
          resume_d = ST_MOVE;
        end else if (step_en_q) begin
          if (pend_legal) begin
            take_turn = 1'b1;
          end else if (cur_legal) begin
            x_d = cur_nx;
            y_d = cur_ny;
          end else begin
            state_d = ST_IDLE;
          end
        end
      ST_PAUSED:
        if (!pm_if.pause) state_d = resume_q;
      default: state_d = ST_IDLE;
    endcase
    if (take_turn) begin
      x_d   = pend_nx;
      y_d   = pend_ny;
      dir_d = turn_q;
    end
  end

  // A turn that arrived after the one being applied must survive the clear.
  always_comb begin
    pending_d = pending_q;
    if (btn_dir != DIR_NONE)                    pending_d = btn_dir;
    else if (take_turn && pending_q == turn_q)  pending_d = DIR_NONE;
  end

  assign pm_if.pm_xpos      = x_q;
  assign pm_if.pm_ypos      = y_q;
  assign pm_if.pm_direction = dir_q;
  assign pm_if.moving       = (state_q == ST_MOVE);

endmodule

// File: doc/pacman_motion_ctrl.md
Name: pacman_motion_ctrl

Overview:
- Produces the Pac-Man sprite position and facing (pm_xpos, pm_ypos, pm_direction) consumed by the sprite renderer.
- Samples the player direction buttons and buffers the last requested turn.
- Advances the sprite a fixed step on frame boundaries only, so coordinates never change during active video.
- Sits between the synchronised button inputs and the sprite/view layer.

Parameters:
- X_MIN, 144: left playfield limit for pm_xpos, inclusive.
- X_MAX, 754: right limit for pm_xpos, inclusive; 784 minus sprite width 30.
- Y_MIN, 35: top limit for pm_ypos, inclusive.
- Y_MAX, 485: bottom limit for pm_ypos, inclusive; 515 minus sprite height 30.
- X_START, 434: pm_xpos after reset.
- Y_START, 260: pm_ypos after reset.
- STEP, 2: pixels moved per step, 1..15.
- FRAME_DIV, 2: frames per step, 1..15.

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, asserted at start of vertical blanking
- btn_up  in  1  level, already synchronised
- btn_down  in  1  level, already synchronised
- btn_left  in  1  level, already synchronised
- btn_right  in  1  level, already synchronised
- pause  in  1  level; freezes motion while high
- pm_xpos  out  10  sprite top-left x, registered
- pm_ypos  out  10  sprite top-left y, registered
- pm_direction  out  4  one-hot facing: bit0 right, bit1 left, bit2 up, bit3 down; registered
- moving  out  1  high while in MOVE state

Behaviour:
- Reset (rst low, asynchronous):
  - pm_xpos=X_START, pm_ypos=Y_START, pm_direction=4'b0001.
  - moving=0, pending turn cleared, frame counter=0, state IDLE.
- Button sampling, every clk:
  - Any button high loads the pending register with its one-hot code.
  - Priority when several are high: up > down > left > right.
  - With no button high, pending holds its value.
- Frame counter (4-bit):
  - Increments on frame_tick while not PAUSED.
  - On reaching FRAME_DIV-1 with frame_tick, it wraps to 0 and raises step_en for exactly the next cycle.
- State machine: IDLE, MOVE, PAUSED.
  - IDLE -> MOVE: on step_en when pending is non-zero and the step in the pending direction is legal.
  - MOVE -> IDLE: on step_en when the step in the current direction is illegal (wall). Direction is retained.
  - Any state -> PAUSED: while pause=1. The frame counter is held.
  - PAUSED -> previous state: when pause falls, on the next cycle. step_en is suppressed while paused.
- Step, on the step_en cycle:
  - If pending is non-zero and a move in pending is legal: pm_direction <= pending, pending cleared, move in pending.
  - Else if the move in the current direction is legal: move in the current direction.
  - Else: no position change, go to IDLE.
  - Reversal (opposite of current) is treated like any turn.
- Legality:
  - The new coordinate must stay within [MIN, MAX] on the moved axis.
  - A move that would cross a limit clamps exactly to the limit if the current position is not already on it.
  - If the current position is already on the limit, the move is illegal.
- Arithmetic: 10-bit unsigned; compare in 11 bits to avoid wrap below 0.
- Latency:
  - Outputs change only on the cycle after step_en, i.e. 2 clk after the qualifying frame_tick.
  - They are stable for the rest of the frame.
- frame_tick and a button change in the same cycle: the button is loaded into pending first, and takes effect on the next step_en, not the current one.

Optional Feature:
- Macro: PACMAN_TUNNEL_EN.
- Defined: moving right from pm_xpos=X_MAX sets pm_xpos=X_MIN; moving left from X_MIN sets X_MAX. These steps are legal, so the sprite never stops at a horizontal limit. Vertical behaviour is unchanged.
- Undefined: horizontal limits clamp and stop as described in Behaviour.

Decomposition:
- Shared package pacman_pkg holds:
  - direction one-hot constants DIR_RIGHT/LEFT/UP/DOWN;
  - state encoding;
  - playfield limit defaults, also used by pacman_view.
- Sub-module pacman_step_calc (combinational) takes position, direction, STEP and limits, and returns next position plus legal flag. It is instantiated twice, for the pending and current directions.

Test Plan:
- Reset with FRAME_DIV=1, STEP=2: outputs (434, 260, 0001), moving=0. No buttons for 5 frames -> outputs unchanged.
- Pulse btn_up for one cycle, then 3 frame_ticks: pm_direction=0100; pm_ypos 258, 256, 254, each change 2 clk after its tick; moving=1.
- Move right from x=750 with STEP=2, macro undefined: 752, then 754. The next step gives no change, moving=0, direction stays 0001.
- Same run with PACMAN_TUNNEL_EN defined: 752, 754, then 144.
- Raise pause for 4 frame_ticks mid-move: no position change. After release, the step occurs on the FRAME_DIV-th tick, counter resumed from its held value.
- Raise btn_down in the same cycle as frame_tick: no turn on that step. The turn is applied on the following step_en.
- Assert rst mid-move, asynchronously between clk edges: outputs return to reset values immediately.
